key_debouncer: RTL and testbench

- Input-conditioning stage directly upstream of the piano controller.
- Synchronises and debounces the 7 piano keys and the 2 song-select buttons.
- Outputs clean key levels, single-cycle press pulses and a priority-encoded note code.
- Maintains the wrapping song index consumed by the controller.

---
 rtl/key_debouncer_if.sv | 24 ++
 rtl/key_debouncer.sv | 138 +++++++++++++
 tb/tb_key_debouncer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/key_debouncer_if.sv
// Signal bundle between the raw key/button inputs and the debounced outputs
// consumed by the piano controller.
interface key_debouncer_if #(
    parameter int IDX_W = 2
);
    logic [6:0]       keys;
    logic [1:0]       song_select;
    logic [6:0]       keys_stable;
    logic [6:0]       key_press;
    logic [3:0]       note_code;
    logic             next_pulse;
    logic             prev_pulse;
    logic [IDX_W-1:0] song_idx;

    modport master (
        output keys, song_select,
        input  keys_stable, key_press, note_code, next_pulse, prev_pulse, song_idx
    );

    modport slave (
        input  keys, song_select,
        output keys_stable, key_press, note_code, next_pulse, prev_pulse, song_idx
    );
endinterface

// File: rtl/key_debouncer.sv
// Synchronises and debounces 7 piano keys and 2 song-select buttons; produces
// press pulses, a lowest-index note code and the wrapping song index.
//
// state      | meaning
// IDLE_LOW   | accepted level 0, sync agrees
// COUNT_UP   | accepted level 0, counting consecutive 1 samples
// IDLE_HIGH  | accepted level 1, sync agrees
// COUNT_DOWN | accepted level 1, counting consecutive 0 samples
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int NUM_SONGS       = 4,
    parameter int IDX_W           = 2
) (
    input logic          clk,
    input logic          reset,
    key_debouncer_if.slave bus
);
    localparam int NUM_LINES = 9;
    localparam int CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SONGS - 1);

    typedef enum logic [1:0] {IDLE_LOW, COUNT_UP, IDLE_HIGH, COUNT_DOWN} line_state_t;

    logic [NUM_LINES-1:0] raw, sync_a, sync_b;
    logic [NUM_LINES-1:0] stable, stable_d;
    line_state_t          state_q [NUM_LINES];
    line_state_t          state_d [NUM_LINES];
    logic [CNT_W-1:0]     cnt_q   [NUM_LINES];
    logic [CNT_W-1:0]     cnt_d   [NUM_LINES];

    logic [6:0]       key_press_q;
    logic [3:0]       note_q, note_next;
    logic [1:0]       sel_rise;
    logic             next_q, prev_q;
    logic [IDX_W-1:0] idx_q;

    // Bits 6:0 are the keys, bit 7 is "next", bit 8 is "previous".
    assign raw = {bus.song_select, bus.keys};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                state_q[i] <= IDLE_LOW;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LINES; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // First mismatching sample loads 1, so the flip lands on the
    // DEBOUNCE_CYCLES-th consecutive mismatch.
    always_comb begin
        stable = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = '0;
            case (state_q[i])
                IDLE_LOW: begin
                    if (sync_b[i]) begin
                        state_d[i] = COUNT_UP;
                        cnt_d[i]   = CNT_W'(1);
                    end
                end
                COUNT_UP: begin
                    if (!sync_b[i])              state_d[i] = IDLE_LOW;
                    else if (cnt_q[i] == CNT_LAST) state_d[i] = IDLE_HIGH;
                    else                         cnt_d[i]   = cnt_q[i] + CNT_W'(1);
                end
                IDLE_HIGH: begin
                    if (!sync_b[i]) begin
                        state_d[i] = COUNT_DOWN;
                        cnt_d[i]   = CNT_W'(1);
                    end
                end
                COUNT_DOWN: begin
                    if (sync_b[i])               state_d[i] = IDLE_HIGH;
                    else if (cnt_q[i] == CNT_LAST) state_d[i] = IDLE_LOW;
                    else                         cnt_d[i]   = cnt_q[i] + CNT_W'(1);
                end
                default: state_d[i] = IDLE_LOW;
            endcase
            stable[i] = (state_q[i] == IDLE_HIGH) || (state_q[i] == COUNT_DOWN);
        end
    end

    always_comb begin
        note_next = '0;
        for (int i = 6; i >= 0; i--) begin
            if (stable[i]) note_next = 4'(i + 1);
        end
    end

    assign sel_rise = stable[8:7] & ~stable_d[8:7];

    // Simultaneous next+prev rises cancel each other out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_d    <= '0;
            key_press_q <= '0;
            note_q      <= '0;
            next_q      <= 1'b0;
            prev_q      <= 1'b0;
            idx_q       <= '0;
        end else begin
            stable_d    <= stable;
            key_press_q <= stable[6:0] & ~stable_d[6:0];
            note_q      <= note_next;
            next_q      <= (sel_rise == 2'b01);
            prev_q      <= (sel_rise == 2'b10);
            if (sel_rise == 2'b01)
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            else if (sel_rise == 2'b10)
                idx_q <= (idx_q == '0) ? IDX_LAST : idx_q - IDX_W'(1);
        end
    end

    assign bus.keys_stable = stable[6:0];
    assign bus.key_press   = key_press_q;
    assign bus.note_code   = note_q;
    assign bus.next_pulse  = next_q;
    assign bus.prev_pulse  = prev_q;
    assign bus.song_idx    = idx_q;
endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer (DEBOUNCE_CYCLES=4, NUM_SONGS=4): expected
// pulses are queued at stimulus time and matched by a monitor.
module tb_key_debouncer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // {key_press, note_code, next_pulse, prev_pulse, song_idx}
    logic [14:0] sb[$];

    key_debouncer_if #(.IDX_W(2)) dbg_if ();

    key_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .NUM_SONGS      (4),
        .IDX_W          (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (dbg_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [14:0] mk(input logic [6:0] kp, input logic [3:0] nc,
                                       input logic nx, input logic pv, input logic [1:0] idx);
        return {kp, nc, nx, pv, idx};
    endfunction

    always @(negedge clk) begin
        logic [14:0] act;
        logic [14:0] exp;
        if (reset && (dbg_if.key_press != 0 || dbg_if.next_pulse || dbg_if.prev_pulse)) begin
            act = {dbg_if.key_press, dbg_if.note_code, dbg_if.next_pulse,
                   dbg_if.prev_pulse, dbg_if.song_idx};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got %0h expected no pulse", act);
            end else begin
                exp = sb.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL pulse: got %0h expected %0h", act, exp);
                end
            end
        end
    end

    task automatic song_press(input logic [1:0] b, input logic nx, input logic pv,
                              input logic [1:0] idx);
        dbg_if.song_select = b;
        if (b != 2'b11) sb.push_back(mk(7'd0, 4'd0, nx, pv, idx));
        wait_neg(10);
        dbg_if.song_select = 2'b00;
        wait_neg(12);
    endtask

    initial begin
        int seq [7] = '{1, 1, 0, 1, 1, 1, 1};
        dbg_if.keys        = '0;
        dbg_if.song_select = '0;

        // 1: reset and quiet period
        wait_neg(3);
        check("rst_keys_stable", 32'(dbg_if.keys_stable), 32'h0);
        check("rst_note_code", 32'(dbg_if.note_code), 32'h0);
        check("rst_song_idx", 32'(dbg_if.song_idx), 32'h0);
        reset = 1'b1;
        wait_neg(20);
        check("idle_outputs", 32'({dbg_if.keys_stable, dbg_if.key_press, dbg_if.note_code,
                                   dbg_if.song_idx}), 32'h0);

        // 2: clean press of key 2
        dbg_if.keys = 7'b0000100;
        sb.push_back(mk(7'b0000100, 4'd3, 1'b0, 1'b0, 2'd0));
        repeat (5) @(posedge clk);
        #1 check("k2_edge5", 32'(dbg_if.keys_stable[2]), 32'h0);
        @(posedge clk);
        #1 check("k2_edge6", 32'(dbg_if.keys_stable[2]), 32'h1);
        wait_neg(8);
        dbg_if.keys = '0;
        wait_neg(12);
        check("k2_released", 32'({dbg_if.keys_stable, dbg_if.note_code}), 32'h0);

        // 3: glitchy key 0
        sb.push_back(mk(7'b0000001, 4'd1, 1'b0, 1'b0, 2'd0));
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            dbg_if.keys[0] = seq[i][0];
        end
        repeat (2) @(posedge clk);
        #1 check("k0_edge8", 32'(dbg_if.keys_stable[0]), 32'h0);
        @(posedge clk);
        #1 check("k0_edge9", 32'(dbg_if.keys_stable[0]), 32'h1);
        wait_neg(8);
        dbg_if.keys = '0;
        wait_neg(12);

        // 4: keys 3+5, then release 3
        dbg_if.keys = 7'b0101000;
        sb.push_back(mk(7'b0101000, 4'd4, 1'b0, 1'b0, 2'd0));
        wait_neg(12);
        check("k35_note", 32'(dbg_if.note_code), 32'd4);
        dbg_if.keys = 7'b0100000;
        wait_neg(10);
        check("k5_note", 32'(dbg_if.note_code), 32'd6);
        check("k5_stable", 32'(dbg_if.keys_stable), 32'h20);
        dbg_if.keys = '0;
        wait_neg(12);
        check("all_released_note", 32'(dbg_if.note_code), 32'd0);

        // 5: song selection
        song_press(2'b01, 1'b1, 1'b0, 2'd1);
        song_press(2'b01, 1'b1, 1'b0, 2'd2);
        song_press(2'b01, 1'b1, 1'b0, 2'd3);
        song_press(2'b01, 1'b1, 1'b0, 2'd0);
        song_press(2'b01, 1'b1, 1'b0, 2'd1);
        song_press(2'b10, 1'b0, 1'b1, 2'd0);
        song_press(2'b10, 1'b0, 1'b1, 2'd3);
        check("idx_after_prev", 32'(dbg_if.song_idx), 32'd3);
        song_press(2'b11, 1'b0, 1'b0, 2'd3);
        check("idx_after_both", 32'(dbg_if.song_idx), 32'd3);

        // 6: reset pulse while key 6 is counting
        dbg_if.keys = 7'b1000000;
        wait_neg(3);
        reset = 1'b0;
        #1;
        check("midrst_song_idx", 32'(dbg_if.song_idx), 32'd0);
        check("midrst_outputs", 32'({dbg_if.keys_stable, dbg_if.key_press, dbg_if.note_code}),
              32'h0);
        @(negedge clk);
        reset = 1'b1;
        sb.push_back(mk(7'b1000000, 4'd7, 1'b0, 1'b0, 2'd0));
        repeat (5) @(posedge clk);
        #1 check("k6_edge5", 32'(dbg_if.keys_stable[6]), 32'h0);
        @(posedge clk);
        #1 check("k6_edge6", 32'(dbg_if.keys_stable[6]), 32'h1);
        wait_neg(10);
        dbg_if.keys = '0;
        wait_neg(12);

        check("pending_pulses", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
